adc_capture: RTL and testbench



---
 rtl/adc_capture_pkg.sv | 15 +
 rtl/sdp_ram.sv | 46 ++++
 rtl/adc_capture.sv | 162 ++++++++++++++++
 tb/tb_adc_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types and default sizes for the triggered capture buffer
package adc_capture_pkg;

    localparam int DW_DEF = 12;
    localparam int AW_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
    parameter int DW = 12,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // sample array is never reset; contents are only meaningful after a full window
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // read data holds its value unless a read is requested
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // read data register, cleared so the output reads 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - pre/post-trigger waveform capture with chronological readout
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk_fs,
    input  logic          rst,
    input  logic [DW-1:0] adc_data_s,
    input  logic          arm,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_edge,
    input  logic [AW-1:0] pre_len,
    input  logic          force_trig,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] trig_addr,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    cap_state_t    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] pre_len_q, pre_len_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [DW-1:0] prev_q, prev_d;
    logic [DW-1:0] lvl_q, lvl_d;
    logic          prev_ok_q, prev_ok_d;
    logic          edge_q, edge_d;
    logic          rd_valid_q, rd_valid_d;

    logic          wr_en;
    logic          rise_hit;
    logic          fall_hit;
    logic          rd_ok;
    logic [AW-1:0] post_len;
    logic [AW-1:0] rd_phys;

    // trigger qualification on the incoming sample against the last written one
    always_comb begin
        rise_hit = prev_ok_q && ($signed(prev_q) < $signed(lvl_q))
                             && ($signed(adc_data_s) >= $signed(lvl_q));
        fall_hit = prev_ok_q && ($signed(prev_q) > $signed(lvl_q))
                             && ($signed(adc_data_s) <= $signed(lvl_q));
        post_len = {AW{1'b1}} - pre_len_q;
    end

    // capture FSM: one cnt register serves both the pre- and post-trigger countdowns
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        pre_len_d   = pre_len_q;
        trig_addr_d = trig_addr_q;
        prev_d      = prev_q;
        lvl_d       = lvl_q;
        prev_ok_d   = prev_ok_q;
        edge_d      = edge_q;
        wr_en       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    pre_len_d = pre_len;
                    lvl_d     = trig_level;
                    edge_d    = trig_edge;
                    prev_ok_d = 1'b0;
                    cnt_d     = pre_len;
                    state_d   = (pre_len == '0) ? WAIT : PRE;
                end
            end
            PRE: begin
                wr_en = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AW'(1)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wr_en = 1'b1;
                if (force_trig || (edge_q ? fall_hit : rise_hit)) begin
                    trig_addr_d = wr_ptr_q;
                    cnt_d       = post_len;
                    state_d     = (post_len == '0) ? DONE : POST;
                end
            end
            POST: begin
                wr_en = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // every write advances the ring pointer and becomes the next comparison reference
        if (wr_en) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            prev_d    = adc_data_s;
            prev_ok_d = 1'b1;
        end
    end

    // read path: only a frozen window is readable, and a new arm takes priority
    always_comb begin
        rd_ok      = rd_en && (state_q == DONE) && !arm;
        rd_valid_d = rd_ok;
        rd_phys    = trig_addr_q - pre_len_q + rd_addr;
    end

    // state and datapath registers
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_len_q   <= '0;
            trig_addr_q <= '0;
            prev_q      <= '0;
            lvl_q       <= '0;
            prev_ok_q   <= 1'b0;
            edge_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pre_len_q   <= pre_len_d;
            trig_addr_q <= trig_addr_d;
            prev_q      <= prev_d;
            lvl_q       <= lvl_d;
            prev_ok_q   <= prev_ok_d;
            edge_q      <= edge_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign busy      = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    assign done      = (state_q == DONE);
    assign trig_addr = trig_addr_q;
    assign rd_valid  = rd_valid_q;

    sdp_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk   (clk_fs),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (adc_data_s),
        .re    (rd_ok),
        .raddr (rd_phys),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - randomized scoreboard bench for the capture buffer
module tb_adc_capture;

    localparam int DW = 12;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk_fs = 1'b0;
    logic          rst;
    logic [DW-1:0] adc_data_s;
    logic          arm;
    logic [DW-1:0] trig_level;
    logic          trig_edge;
    logic [AW-1:0] pre_len;
    logic          force_trig;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int stim[$];
    bit frc[$];
    int wp      = 0;
    int last_wr = 0;

    always #5 clk_fs = ~clk_fs;

    adc_capture #(.DW(DW), .AW(AW)) dut (
        .clk_fs     (clk_fs),
        .rst        (rst),
        .adc_data_s (adc_data_s),
        .arm        (arm),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pre_len    (pre_len),
        .force_trig (force_trig),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    task automatic tick();
        @(posedge clk_fs);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit crosses(input bit e, input int lvl, input int p, input int c);
        return e ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
    endfunction

    // monitor: every returned read is matched against the oldest outstanding request
    initial begin
        forever begin
            @(posedge clk_fs);
            #1;
            if (rd_valid) begin
                if (exp_q.size() == 0) check("rd_valid_unexpected", 1, 0);
                else check("rd_data", int'($signed(rd_data)), exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_state();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_trig_addr", int'(trig_addr), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
    endtask

    // window model: trigger index from the sample list, window = N samples starting P before it
    task automatic run_capture(input int p, input int lvl, input bit e, input bit arm_rd,
                               input int abort_k);
        int t;
        int last;
        int idx[N];
        t = -1;
        for (int k = p + 1; k < stim.size(); k++) begin
            if (frc[k] || (k >= 2 && crosses(e, lvl, stim[k-1], stim[k]))) begin
                t = k;
                break;
            end
        end
        if (t < 0) begin
            check("model_trigger_found", 0, 1);
            return;
        end
        last = t + N - 1 - p;
        while (stim.size() <= last + 1) begin
            stim.push_back(stim[stim.size()-1]);
            frc.push_back(1'b0);
        end
        trig_level = 12'(lvl);
        trig_edge  = e;
        pre_len    = 4'(p);
        for (int k = 0; k <= last; k++) begin
            bit rq;
            adc_data_s = 12'(stim[k]);
            force_trig = frc[k];
            arm        = (k == 0);
            rq         = (k == 2) || (k == 0 && arm_rd);
            rd_en      = rq;
            rd_addr    = 4'($urandom_range(0, N - 1));
            tick();
            arm        = 1'b0;
            rd_en      = 1'b0;
            force_trig = 1'b0;
            if (rq) check("rd_valid_blocked", int'(rd_valid), 0);
            if (k == abort_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                wp  = 0;
                check_reset_state();
                return;
            end
            check("busy_done", int'({busy, done}), (k < last) ? 2 : 1);
        end
        check("trig_addr", int'(trig_addr), (wp + t - 1) % N);
        wp = (wp + last) % N;
        for (int i = 0; i < N; i++) idx[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j;
            int tmp;
            j      = $urandom_range(0, i);
            tmp    = idx[i];
            idx[i] = idx[j];
            idx[j] = tmp;
        end
        for (int i = 0; i < N; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(idx[i]);
            exp_q.push_back(stim[t - p + idx[i]]);
            tick();
            if ($urandom_range(0, 3) == 0) begin
                rd_en = 1'b0;
                tick();
            end
        end
        rd_en = 1'b0;
        tick();
        tick();
        check("rd_drain", exp_q.size(), 0);
        last_wr = stim[t - p + N - 1];
    endtask

    initial begin
        int v;
        int lvl;
        rst        = 1'b1;
        adc_data_s = '0;
        arm        = 1'b0;
        trig_level = '0;
        trig_edge  = 1'b0;
        pre_len    = '0;
        force_trig = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        tick();
        tick();
        check_reset_state();
        rst = 1'b0;
        tick();

        // full-scale ramp, rising through 0
        stim.delete(); frc.delete();
        for (int k = 0; k < 2200; k++) begin
            stim.push_back(-2048 + k);
            frc.push_back(1'b0);
        end
        run_capture(4, 0, 1'b0, 1'b0, -1);

        // same ramp on a falling edge never qualifies; software trigger at sample 100
        for (int k = 0; k < 2200; k++) frc[k] = (stim[k] == 100);
        run_capture(4, 0, 1'b1, 1'b0, -1);

        // step -500 -> +500 with no pre-trigger, force coincident with the edge
        stim.delete(); frc.delete();
        for (int k = 0; k < 40; k++) begin
            stim.push_back((k < 5) ? -500 : 500 + (k - 5));
            frc.push_back(k == 5);
        end
        run_capture(0, 0, 1'b0, 1'b0, -1);

        // first post-arm sample crosses from the stale reference: must not trigger
        lvl = last_wr + 1;
        stim.delete(); frc.delete();
        for (int k = 0; k < 40; k++) begin
            stim.push_back((k == 0) ? lvl - 5 : (k == 10) ? lvl - 50 : (k == 11) ? lvl + 20 : lvl + 5);
            frc.push_back(1'b0);
        end
        run_capture(0, lvl, 1'b0, 1'b0, -1);

        // maximum pre-trigger, crossing on the 50th sample after WAIT entry
        stim.delete(); frc.delete();
        for (int k = 0; k < 90; k++) begin
            if (k < 65)       stim.push_back(int'($urandom_range(0, 2147)) - 2048);
            else if (k == 65) stim.push_back(100 + int'($urandom_range(0, 1947)));
            else              stim.push_back(int'($urandom_range(0, 4095)) - 2048);
            frc.push_back(1'b0);
        end
        run_capture(N - 1, 100, 1'b0, 1'b0, -1);

        // random walks with random window, level, edge and stray forces
        for (int it = 0; it < 4; it++) begin
            int p;
            p = $urandom_range(0, N - 1);
            lvl = int'($urandom_range(0, 600)) - 300;
            v = int'($urandom_range(0, 400)) - 200;
            stim.delete(); frc.delete();
            for (int k = 0; k < p + 80; k++) begin
                v = v + int'($urandom_range(0, 200)) - 100;
                if (v > 2047) v = 2047;
                if (v < -2048) v = -2048;
                stim.push_back(v);
                frc.push_back((k == p + 60) || ($urandom_range(0, 40) == 0));
            end
            run_capture(p, lvl, 1'($urandom_range(0, 1)), (it == 1), -1);
        end

        // reset during POST, read while idle, then a clean capture and an arm+read collision
        stim.delete(); frc.delete();
        for (int k = 0; k < 60; k++) begin
            stim.push_back(-20 + k);
            frc.push_back(1'b0);
        end
        run_capture(3, 0, 1'b0, 1'b0, 25);
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        check("rd_idle_blocked", int'(rd_valid), 0);
        run_capture(3, 0, 1'b0, 1'b0, -1);
        run_capture(2, 10, 1'b0, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
